// File: rtl/vx_commit_arbiter_if.sv
// ---------------------------------------------------------------------------
// vx_commit_arbiter_if
// Commit and writeback bundle between the execute units and the issue stage.
//   commit_*    : one slot per source (0 ALU, 1 LSU, 2 CSR, 3 FPU, 4 GPU),
//                 valid/ready handshake, payload held by the source until ready.
//   writeback_* : single registered writeback, no back-pressure.
// Modports:
//   slave  : the commit arbiter (consumes commits, produces writeback)
//   master : the environment (execute units + issue stage)
// ---------------------------------------------------------------------------
interface vx_commit_arbiter_if #(
   parameter int NUM_REQS    = 5,
   parameter int NUM_THREADS = 4,
   parameter int NW_BITS     = 2
);
   logic [NUM_REQS-1:0]                        commit_valid;
   logic [NUM_REQS-1:0]                        commit_ready;
   logic [NUM_REQS-1:0][NW_BITS-1:0]           commit_wid;
   logic [NUM_REQS-1:0][NUM_THREADS-1:0]       commit_tmask;
   logic [NUM_REQS-1:0][31:0]                  commit_PC;
   logic [NUM_REQS-1:0]                        commit_wb;
   logic [NUM_REQS-1:0][4:0]                   commit_rd;
   logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0] commit_data;
   logic [NUM_REQS-1:0]                        commit_eop;

   logic                                       writeback_valid;
   logic [NW_BITS-1:0]                         writeback_wid;
   logic [NUM_THREADS-1:0]                     writeback_tmask;
   logic [31:0]                                writeback_PC;
   logic [4:0]                                 writeback_rd;
   logic [NUM_THREADS-1:0][31:0]               writeback_data;
   logic                                       writeback_eop;

   modport slave (
      input  commit_valid, commit_wid, commit_tmask, commit_PC, commit_wb,
             commit_rd, commit_data, commit_eop,
      output commit_ready,
      output writeback_valid, writeback_wid, writeback_tmask, writeback_PC,
             writeback_rd, writeback_data, writeback_eop
   );

   modport master (
      output commit_valid, commit_wid, commit_tmask, commit_PC, commit_wb,
             commit_rd, commit_data, commit_eop,
      input  commit_ready,
      input  writeback_valid, writeback_wid, writeback_tmask, writeback_PC,
             writeback_rd, writeback_data, writeback_eop
   );
endinterface

// File: rtl/vx_commit_arbiter.sv
// ---------------------------------------------------------------------------
// vx_commit_arbiter
// Collects completed results from the execute units, grants one register-
// writing commit per cycle round-robin and drives a registered writeback into
// the issue stage. Commits that do not write a register are accepted at once.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : commit_* inputs / commit_ready, writeback_* outputs
//   perf_wb_stalls : cycles with more than one writeback candidate
// ---------------------------------------------------------------------------

// Per-source slot: candidate detection, ready, and a grant-masked payload so
// the top can merge all slots with a plain OR.
module vx_commit_slot #(
   parameter int PKT_W = 8
) (
   input  logic             valid,
   input  logic             wb,
   input  logic             grant,
   input  logic [PKT_W-1:0] pkt,
   output logic             cand,
   output logic             ready,
   output logic [PKT_W-1:0] pkt_sel
);
   assign cand    = valid & wb;
   assign ready   = ~wb | grant;
   assign pkt_sel = pkt & {PKT_W{grant}};
endmodule

module vx_commit_arbiter #(
   parameter int CORE_ID       = 0,
   parameter int NUM_REQS      = 5,
   parameter int NUM_THREADS   = 4,
   parameter int NW_BITS       = 2,
   parameter int PERF_CTR_BITS = 44
) (
   input  logic                     clk,
   input  logic                     reset,
   vx_commit_arbiter_if.slave       bus,
   output logic [PERF_CTR_BITS-1:0] perf_wb_stalls
);
   localparam int RR_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int STAGES = 1;
   localparam logic [RR_W-1:0] LAST = RR_W'(NUM_REQS - 1);

   if (NUM_REQS < 2 || CORE_ID < 0) begin : g_bad_param
      $error("vx_commit_arbiter: NUM_REQS must be >= 2 and CORE_ID >= 0");
   end

   typedef struct packed {
      logic [NW_BITS-1:0]           wid;
      logic [NUM_THREADS-1:0]       tmask;
      logic [31:0]                  pc;
      logic [4:0]                   rd;
      logic [NUM_THREADS-1:0][31:0] data;
      logic                         eop;
   } wb_pkt_t;

   localparam int PKT_W = $bits(wb_pkt_t);

   logic [RR_W-1:0]                rr_ptr;
   logic [RR_W-1:0]                rr_next;
   logic [NUM_REQS-1:0]            cand;
   logic [NUM_REQS-1:0]            grant;
   logic [RR_W-1:0]                grant_idx;
   logic                           grant_any;
   logic                           multi_cand;
   wb_pkt_t [NUM_REQS-1:0]         src_pkt;
   logic [NUM_REQS-1:0][PKT_W-1:0] sel_pkt;
   logic [PKT_W-1:0]               wb_next;
   wb_pkt_t                        wb_q;
   logic [STAGES:1]                vld_pipe;

   // ---- per-source slots -------------------------------------------------
   for (genvar i = 0; i < NUM_REQS; i++) begin : g_slot
      assign src_pkt[i].wid   = bus.commit_wid[i];
      assign src_pkt[i].tmask = bus.commit_tmask[i];
      assign src_pkt[i].pc    = bus.commit_PC[i];
      assign src_pkt[i].rd    = bus.commit_rd[i];
      assign src_pkt[i].data  = bus.commit_data[i];
      assign src_pkt[i].eop   = bus.commit_eop[i];

      vx_commit_slot #(.PKT_W(PKT_W)) u_slot (
         .valid   (bus.commit_valid[i]),
         .wb      (bus.commit_wb[i]),
         .grant   (grant[i]),
         .pkt     (src_pkt[i]),
         .cand    (cand[i]),
         .ready   (bus.commit_ready[i]),
         .pkt_sel (sel_pkt[i])
      );
   end

   // ---- round-robin search starting at rr_ptr ----------------------------
   // No grant while reset is high, so nothing is accepted that the cleared
   // register would then lose; ungranted sources simply retry afterwards.
   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      if (!reset) begin
         for (int k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            if (!grant_any && cand[idx]) begin
               grant[idx] = 1'b1;
               grant_idx  = RR_W'(idx);
               grant_any  = 1'b1;
            end
         end
      end
   end

   assign rr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;

   // More than one candidate <=> clearing the lowest set bit leaves bits set.
   assign multi_cand = |(cand & (cand - 1'b1));

   // Grant is one-hot, so OR-merging the masked slot payloads is the mux.
   always_comb begin
      wb_next = '0;
      for (int i = 0; i < NUM_REQS; i++) wb_next = wb_next | sel_pkt[i];
   end

   // ---- state ------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr         <= '0;
         vld_pipe       <= '0;
         wb_q           <= '0;
         perf_wb_stalls <= '0;
      end else begin
         vld_pipe[1] <= grant_any;
         if (grant_any) begin
            rr_ptr <= rr_next;
            wb_q   <= wb_pkt_t'(wb_next);
         end
         if (multi_cand) perf_wb_stalls <= perf_wb_stalls + PERF_CTR_BITS'(1);
      end
   end

   // ---- writeback outputs ------------------------------------------------
   assign bus.writeback_valid = vld_pipe[STAGES];
   assign bus.writeback_wid   = wb_q.wid;
   assign bus.writeback_tmask = wb_q.tmask;
   assign bus.writeback_PC    = wb_q.pc;
   assign bus.writeback_rd    = wb_q.rd;
   assign bus.writeback_data  = wb_q.data;
   assign bus.writeback_eop   = wb_q.eop;
endmodule
